// File: rtl/hdmi_text_axi_vram_port.sv
// ---------------------------------------------------------------------------
// hdmi_text_axi_vram_port
//
// AXI4-Lite slave that gives a CPU access to the text-mode video RAM of the
// HDMI text renderer and to its control register.
//
// Address map (word index = addr[11:2], all other address bits ignored):
//   0   .. 599  : character VRAM, reached via the BRAM port-A signals
//   600         : ctrl_reg (fg/bg palette for the renderer)
//   601 .. 1023 : unmapped (writes dropped, reads return 0)
//
// Only one transaction is in flight at a time. AW and W may arrive in either
// order and are latched independently. A write that arrives together with a
// read wins.
//
// Ports
//   axi_aclk, axi_aresetn     : clock, asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b*     : AXI4-Lite write address / data / response
//   axi_ar*/axi_r*            : AXI4-Lite read address / data
//   vram_addr/din/we/en/dout  : BRAM port A (read data valid 1 cycle after en)
//   ctrl_reg                  : control register to the text renderer
// ---------------------------------------------------------------------------
module hdmi_text_axi_vram_port #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  // write address
  input  logic [C_AXI_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [2:0]                  axi_awprot,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  // write data
  input  logic [C_AXI_DATA_WIDTH-1:0] axi_wdata,
  input  logic [3:0]                  axi_wstrb,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  // write response
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  // read address
  input  logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [2:0]                  axi_arprot,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  // read data
  output logic [C_AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]                  axi_rresp,
  output logic                        axi_rvalid,
  input  logic                        axi_rready,
  // BRAM port A
  output logic [9:0]                  vram_addr,
  output logic [C_AXI_DATA_WIDTH-1:0] vram_din,
  output logic [3:0]                  vram_we,
  output logic                        vram_en,
  input  logic [C_AXI_DATA_WIDTH-1:0] vram_dout,
  // renderer control
  output logic [31:0]                 ctrl_reg
);

  localparam logic [9:0] VRAM_WORDS = 10'd600;
  localparam logic [9:0] CTRL_INDEX = 10'd600;

  typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_DATA} state_t;

  state_t state, next_state;

  logic                        aw_latched, w_latched;
  logic                        wr_pend;   // write issued, response next cycle
  logic                        rd_phase;  // second RD_WAIT cycle: dout valid
  logic                        run;       // low until first edge after reset
  logic [9:0]                  aw_index, ar_index;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [3:0]                  wstrb_q;

  logic aw_hs, w_hs, ar_hs, do_write;

  // Prot and the ignored address bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{axi_awprot, axi_arprot,
                         axi_awaddr[C_AXI_ADDR_WIDTH-1:12], axi_awaddr[1:0],
                         axi_araddr[C_AXI_ADDR_WIDTH-1:12], axi_araddr[1:0]};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= next_state;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_arready = 1'b0;
    axi_bvalid  = 1'b0;
    axi_rvalid  = 1'b0;
    axi_bresp   = 2'b00;
    axi_rresp   = 2'b00;

    unique case (state)
      IDLE: begin
        axi_awready = run && !aw_latched && !wr_pend;
        axi_wready  = run && !w_latched  && !wr_pend;
        // Ready may depend on valid: a write presented this cycle blocks AR.
        axi_arready = run && !aw_latched && !w_latched && !wr_pend &&
                      !axi_awvalid && !axi_wvalid;
        if (wr_pend)                          next_state = WR_RESP;
        else if (axi_arvalid && axi_arready)  next_state = RD_WAIT;
      end
      WR_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) next_state = IDLE;
      end
      RD_WAIT: begin
        if (rd_phase) next_state = RD_DATA;
      end
      RD_DATA: begin
        axi_rvalid = 1'b1;
        if (axi_rready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign aw_hs    = axi_awvalid && axi_awready;
  assign w_hs     = axi_wvalid  && axi_wready;
  assign ar_hs    = axi_arvalid && axi_arready;
  assign do_write = (state == IDLE) && aw_latched && w_latched;

  // -------------------------------------------------------------------------
  // Datapath: channel latches, BRAM port, ctrl_reg, read data
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      run        <= 1'b0;
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      wr_pend    <= 1'b0;
      rd_phase   <= 1'b0;
      aw_index   <= '0;
      ar_index   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      vram_en    <= 1'b0;
      vram_we    <= '0;
      vram_addr  <= '0;
      vram_din   <= '0;
      ctrl_reg   <= '0;
      axi_rdata  <= '0;
    end else begin
      run     <= 1'b1;
      // Port enables are single-cycle pulses unless re-armed below.
      vram_en <= 1'b0;
      vram_we <= '0;

      if (aw_hs) begin
        aw_latched <= 1'b1;
        aw_index   <= axi_awaddr[11:2];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        wdata_q   <= axi_wdata;
        wstrb_q   <= axi_wstrb;
      end

      if (do_write) begin
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
        wr_pend    <= 1'b1;
        if (aw_index < VRAM_WORDS) begin
          vram_en   <= 1'b1;
          vram_we   <= wstrb_q;
          vram_addr <= aw_index;
          vram_din  <= wdata_q;
        end else if (aw_index == CTRL_INDEX) begin
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) ctrl_reg[b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end else if (wr_pend) begin
        wr_pend <= 1'b0;
      end

      // A read always strobes the BRAM; the mux below picks the source.
      if (ar_hs) begin
        ar_index  <= axi_araddr[11:2];
        vram_en   <= 1'b1;
        vram_addr <= axi_araddr[11:2];
      end

      rd_phase <= (state == RD_WAIT) && !rd_phase;
      if (state == RD_WAIT && rd_phase) begin
        if (ar_index < VRAM_WORDS)       axi_rdata <= vram_dout;
        else if (ar_index == CTRL_INDEX) axi_rdata <= ctrl_reg;
        else                             axi_rdata <= '0;
      end
    end
  end

endmodule

// File: doc/hdmi_text_axi_vram_port.md
HDMI_TEXT_AXI_VRAM_PORT -- requirements
Module: hdmi_text_axi_vram_port

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 16, AXI byte-address width.
REQ-003 SHALL have port axi_aclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port axi_aresetn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have AW ports: axi_awaddr in C_AXI_ADDR_WIDTH; axi_awprot in 3 (ignored); axi_awvalid in 1; axi_awready out 1.
REQ-006 SHALL have W ports: axi_wdata in 32; axi_wstrb in 4; axi_wvalid in 1; axi_wready out 1.
REQ-007 SHALL have B ports: axi_bresp out 2; axi_bvalid out 1; axi_bready in 1.
REQ-008 SHALL have AR ports: axi_araddr in C_AXI_ADDR_WIDTH; axi_arprot in 3 (ignored); axi_arvalid in 1; axi_arready out 1.
REQ-009 SHALL have R ports: axi_rdata out 32; axi_rresp out 2; axi_rvalid out 1; axi_rready in 1.
REQ-010 SHALL have BRAM port-A ports: vram_addr out 10, word index; vram_din out 32, write data; vram_we out 4, byte write enables; vram_en out 1, port enable; vram_dout in 32, read data, valid 1 cycle after vram_en.
REQ-011 SHALL have port ctrl_reg, out, 32, control register (fg/bg palette) fed to the text renderer.

Function
REQ-012 SHALL decode word index = addr[11:2]: 0..599 VRAM, 600 ctrl_reg, 601..1023 unmapped; addr bits above 11 and [1:0] ignored.
REQ-013 SHALL use FSM states IDLE, WR_RESP, RD_WAIT, RD_DATA.
REQ-014 In IDLE, SHALL assert awready when no AW is latched and wready when no W is latched; each channel is latched independently on its valid&ready edge.
REQ-015 When both AW and W are latched, SHALL drop awready/wready, perform the write in the next cycle, and enter WR_RESP.
REQ-016 VRAM write: SHALL drive vram_en=1, vram_we=wstrb, vram_din=wdata, vram_addr=index for exactly one cycle.
REQ-017 ctrl write: SHALL update only the ctrl_reg bytes whose wstrb bit is 1, in the same cycle as a VRAM write would occur.
REQ-018 Unmapped write: SHALL change no state and issue no vram_we.
REQ-019 WR_RESP: SHALL hold bvalid=1, bresp=00 until bready is sampled high, then return to IDLE with bvalid=0.
REQ-020 Write response latency: bvalid SHALL rise in the cycle after the write completes (2 cycles after the last of the AW/W handshakes).
REQ-021 In IDLE, SHALL assert arready only when no AW or W is latched and no write is pending; a write SHALL win when AW/W and AR arrive in the same cycle.
REQ-022 On AR handshake: the next cycle SHALL drive vram_en=1, vram_we=0, vram_addr=index (RD_WAIT); the following cycle SHALL capture vram_dout into rdata and enter RD_DATA.
REQ-023 Read of index 600 SHALL return ctrl_reg; read of unmapped index SHALL return 0; rresp SHALL always be 00.
REQ-024 RD_DATA: SHALL hold rvalid=1 and rdata stable until rready is sampled high, then return to IDLE.
REQ-025 rvalid SHALL rise 2 cycles after the AR handshake edge.
REQ-026 Only one transaction SHALL be outstanding; no AR is accepted during WR_RESP, and no AW/W is accepted during RD_WAIT/RD_DATA.
REQ-027 vram_en and vram_we SHALL be 0 in every cycle not named in REQ-016/REQ-022.

Reset
REQ-028 axi_aresetn low SHALL immediately force IDLE, clear the latched AW/W, and set all ready/valid outputs to 0, bresp/rresp=00, rdata=0, ctrl_reg=0, vram_en=0, vram_we=0, vram_addr=0, vram_din=0.
REQ-029 After release, awready/wready SHALL rise on the first clock edge; a reset mid-transaction SHALL abandon it with no further VRAM write.

Verification
REQ-030 Simultaneous AW/W to addr 0x0010, data 0xDEADBEEF, strb F, bready=1 -> vram_we=F, vram_addr=4 for one cycle; bvalid one cycle later, bresp=00.
REQ-031 Write to 0x0960 data 0x001F6000 strb F, then strb 0x2 data 0x0000AB00 -> ctrl_reg=0x001FAB00; read 0x0960 returns 0x001FAB00.
REQ-032 W issued 3 cycles before AW, then read-back of index 599 (0x095C) with BRAM model -> single write; rdata matches, rvalid 2 cycles after AR handshake.
REQ-033 rready held low 5 cycles during read -> rvalid and rdata stable throughout; bready low 5 cycles -> bvalid held; read of 0x0FFC -> 0, write to 0x0FFC -> no vram_we.
REQ-034 AW/W/AR asserted same cycle -> write completes first, then AR accepted; assert axi_aresetn low during RD_WAIT -> all outputs at reset values immediately, no rvalid after release.
